// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register slave: response codes,
// channel FSM states and the byte-strobe merge helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register array behind the AXI4-Lite slave: one strobed write port,
// combinational read mux, and the flattened contents for the core.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [31:0]           rdata,
    output logic [32*NUM_REGS-1:0] reg_out
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (widx == IDX_W'(i)) begin
                    regs[i] <= strb_merge(regs[i], wdata, wstrb);
                end
            end
        end
    end

    // Indices with no backing register read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with independent write and read channel FSMs in front of
// a small bank of 32-bit control/data registers.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [32*NUM_REGS-1:0]  reg_out
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wstate_e          w_state, w_state_next;
    logic             aw_done, aw_done_next;
    logic             w_done, w_done_next;
    logic [IDX_W-1:0] aw_idx, aw_idx_next;
    logic [31:0]      wdata_hold, wdata_hold_next;
    logic [3:0]       wstrb_hold, wstrb_hold_next;
    logic [1:0]       bresp, bresp_next;

    rstate_e          r_state, r_state_next;
    logic [31:0]      rd_data, rd_data_next;
    logic [1:0]       rresp, rresp_next;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] commit_idx, ar_idx;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;
    logic             commit_ok, ar_ok;
    logic             bank_we;
    logic [31:0]      bank_rdata;

    logic unused_inputs;
    assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign AWREADY = (w_state == W_IDLE) && !aw_done;
    assign WREADY  = (w_state == W_IDLE) && !w_done;
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = bresp;
    assign ARREADY = (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);
    assign RDATA   = rd_data;
    assign RRESP   = rresp;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // A beat arriving this cycle takes precedence over the held copy.
    assign commit_idx  = aw_hs ? AWADDR[ADDR_WIDTH-1:2] : aw_idx;
    assign commit_data = w_hs ? WDATA : wdata_hold;
    assign commit_strb = w_hs ? WSTRB : wstrb_hold;
    assign commit_ok   = 32'(commit_idx) < 32'(NUM_REGS);
    assign ar_idx      = ARADDR[ADDR_WIDTH-1:2];
    assign ar_ok       = 32'(ar_idx) < 32'(NUM_REGS);

    always_comb begin
        w_state_next    = w_state;
        aw_done_next    = aw_done;
        w_done_next     = w_done;
        aw_idx_next     = aw_idx;
        wdata_hold_next = wdata_hold;
        wstrb_hold_next = wstrb_hold;
        bresp_next      = bresp;
        bank_we         = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_next = 1'b1;
                    aw_idx_next  = AWADDR[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_done_next     = 1'b1;
                    wdata_hold_next = WDATA;
                    wstrb_hold_next = WSTRB;
                end
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    bank_we      = commit_ok;
                    bresp_next   = commit_ok ? RESP_OKAY : RESP_SLVERR;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        rd_data_next = rd_data;
        rresp_next   = rresp;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_data_next = ar_ok ? bank_rdata : '0;
                    rresp_next   = ar_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_idx     <= '0;
            wdata_hold <= '0;
            wstrb_hold <= '0;
            bresp      <= RESP_OKAY;
            r_state    <= R_IDLE;
            rd_data    <= '0;
            rresp      <= RESP_OKAY;
        end else begin
            w_state    <= w_state_next;
            aw_done    <= aw_done_next;
            w_done     <= w_done_next;
            aw_idx     <= aw_idx_next;
            wdata_hold <= wdata_hold_next;
            wstrb_hold <= wstrb_hold_next;
            bresp      <= bresp_next;
            r_state    <= r_state_next;
            rd_data    <= rd_data_next;
            rresp      <= rresp_next;
        end
    end

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (ACLK),
        .rst     (ARESET),
        .we      (bank_we),
        .widx    (commit_idx),
        .wdata   (commit_data),
        .wstrb   (commit_strb),
        .ridx    (ar_idx),
        .rdata   (bank_rdata),
        .reg_out (reg_out)
    );

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: vector table plus hand-built
// sequences for channel ordering, back-pressure, collisions and reset.
module tb_axil_reg_slave;

    localparam int AW = 5;
    localparam int NR = 4;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [AW-1:0] AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic [32*NR-1:0] reg_out;

    always #5 ACLK = ~ACLK;

    axil_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .reg_out (reg_out)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [1:0]    bresp;
        logic [31:0]   rdata;
        logic [1:0]    rresp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  bq[$];
    rexp_t       rq[$];
    logic [31:0] shadow [NR];
    vec_t        vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop expected responses as each B/R handshake happens.
    always @(negedge ACLK) begin
        if (ARESET === 1'b0) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    chk("stray_bvalid", {31'b0, BVALID}, 32'd0);
                end else begin
                    chk("bresp", {30'b0, BRESP}, {30'b0, bq.pop_front()});
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    chk("stray_rvalid", {31'b0, RVALID}, 32'd0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rdata", RDATA, e.data);
                    chk("rresp", {30'b0, RRESP}, {30'b0, e.resp});
                end
            end
        end
    end

    task automatic wait_empty();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        chk("resp_pending", bq.size() + rq.size(), 32'd0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp);
        logic aw_pend = 1'b1, w_pend = 1'b1, aw_fire, w_fire;
        int   n = 0;
        bq.push_back(exp);
        AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        while ((aw_pend || w_pend) && n < 20) begin
            @(negedge ACLK);
            aw_fire = aw_pend && AWREADY;
            w_fire  = w_pend && WREADY;
            @(posedge ACLK);
            #1;
            if (aw_fire) begin AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_fire)  begin WVALID = 1'b0;  w_pend = 1'b0;  end
            n++;
        end
        chk("wr_handshake", {30'b0, aw_pend, w_pend}, 32'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        wait_empty();
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [1:0] resp);
        logic pend = 1'b1, fire;
        int   n = 0;
        rq.push_back('{data: data, resp: resp});
        ARADDR = addr; ARVALID = 1'b1;
        while (pend && n < 20) begin
            @(negedge ACLK);
            fire = ARREADY;
            @(posedge ACLK);
            #1;
            if (fire) begin ARVALID = 1'b0; pend = 1'b0; end
            n++;
        end
        chk("rd_handshake", {31'b0, pend}, 32'd0);
        ARVALID = 1'b0;
        wait_empty();
    endtask

    task automatic chk_regs(input string name);
        for (int i = 0; i < NR; i++) begin
            chk(name, reg_out[32*i +: 32], shadow[i]);
        end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        bq.delete();
        rq.delete();
        for (int i = 0; i < NR; i++) shadow[i] = '0;
    endtask

    // Write to 0xC with AW first (mode 0), W first (1) or both together (2).
    task automatic wr_order(input int mode, input logic [31:0] data);
        bq.push_back(OK);
        if (mode != 1) begin AWADDR = 5'h0C; AWVALID = 1'b1; end
        if (mode != 0) begin WDATA = data; WSTRB = 4'hF; WVALID = 1'b1; end
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        if (mode != 2) begin
            repeat (2) begin
                @(negedge ACLK);
                chk("order_early_bvalid", {31'b0, BVALID}, 32'd0);
                chk("order_ready_drop", {31'b0, (mode == 0) ? AWREADY : WREADY}, 32'd0);
                chk("order_no_update", reg_out[96 +: 32], shadow[3]);
                @(posedge ACLK);
                #1;
            end
            if (mode == 0) begin WDATA = data; WSTRB = 4'hF; WVALID = 1'b1; end
            else begin AWADDR = 5'h0C; AWVALID = 1'b1; end
            @(posedge ACLK);
            #1;
            AWVALID = 1'b0; WVALID = 1'b0;
        end
        @(negedge ACLK);
        chk("order_bvalid", {31'b0, BVALID}, 32'd1);
        shadow[3] = data;
        chk_regs("order_update");
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        chk("order_b_done", {31'b0, BVALID}, 32'd0);
        chk("order_ready_back", {30'b0, AWREADY, WREADY}, 32'd3);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{5'h00, 32'h0101FFFF, 4'hF, OK,  32'h0101FFFF, OK};
        vecs[1] = '{5'h04, 32'habcd0001, 4'hF, OK,  32'habcd0001, OK};
        vecs[2] = '{5'h08, 32'hdead0011, 4'hF, OK,  32'hdead0011, OK};
        vecs[3] = '{5'h0C, 32'hbeef0011, 4'hF, OK,  32'hbeef0011, OK};
        vecs[4] = '{5'h04, 32'hFFFFFFFF, 4'hF, OK,  32'hFFFFFFFF, OK};
        vecs[5] = '{5'h04, 32'h12345678, 4'h5, OK,  32'hFF34FF78, OK};
        vecs[6] = '{5'h10, 32'h11111111, 4'hF, ERR, 32'h00000000, ERR};
        vecs[7] = '{5'h06, 32'h00000000, 4'h0, OK,  32'hFF34FF78, OK};
        vecs[8] = '{5'h1C, 32'h22222222, 4'hF, ERR, 32'h00000000, ERR};

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;
        for (int i = 0; i < NR; i++) shadow[i] = '0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        @(negedge ACLK);
        chk("rst_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'd7);
        chk("rst_valids", {30'b0, BVALID, RVALID}, 32'd0);
        chk("rst_resps", {28'b0, BRESP, RRESP}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk_regs("rst_regs");
        @(posedge ACLK);
        #1;

        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].bresp);
            axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
            if (vecs[i].rresp == OK) shadow[int'(vecs[i].addr[4:2])] = vecs[i].rdata;
            @(negedge ACLK);
            chk_regs("vec_regs");
            @(posedge ACLK);
            #1;
        end

        wr_order(0, 32'h11110000);
        wr_order(1, 32'h22220000);
        wr_order(2, 32'h33330000);

        // Write and read of 0x8 commit on the same edge: read sees old value.
        bq.push_back(OK);
        rq.push_back('{data: 32'hdead0011, resp: OK});
        AWADDR = 5'h08; AWVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = 5'h08; ARVALID = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        wait_empty();
        shadow[2] = 32'hA5A5A5A5;
        axi_read(5'h08, 32'hA5A5A5A5, OK);

        // B back-pressure on an out-of-range write.
        BREADY = 1'b0;
        bq.push_back(ERR);
        AWADDR = 5'h10; AWVALID = 1'b1; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        repeat (5) begin
            @(negedge ACLK);
            chk("bp_bvalid", {31'b0, BVALID}, 32'd1);
            chk("bp_bresp", {30'b0, BRESP}, {30'b0, ERR});
            chk("bp_aw_w_ready", {30'b0, AWREADY, WREADY}, 32'd0);
        end
        BREADY = 1'b1;
        wait_empty();
        @(negedge ACLK);
        chk_regs("bp_regs");
        @(posedge ACLK);
        #1;

        // R back-pressure.
        RREADY = 1'b0;
        rq.push_back('{data: 32'h0101FFFF, resp: OK});
        ARADDR = 5'h00; ARVALID = 1'b1;
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        repeat (5) begin
            @(negedge ACLK);
            chk("bp_rvalid", {31'b0, RVALID}, 32'd1);
            chk("bp_rdata", RDATA, 32'h0101FFFF);
            chk("bp_arready", {31'b0, ARREADY}, 32'd0);
        end
        RREADY = 1'b1;
        wait_empty();

        // Reset while B and R responses are outstanding.
        BREADY = 1'b0; RREADY = 1'b0;
        AWADDR = 5'h04; AWVALID = 1'b1; WDATA = 32'h00000077; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = 5'h0C; ARVALID = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge ACLK);
        chk("pre_rst_valids", {30'b0, BVALID, RVALID}, 32'd3);
        @(posedge ACLK);
        #1;
        do_reset();
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        chk("abort_valids", {30'b0, BVALID, RVALID}, 32'd0);
        chk("abort_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'd7);
        chk("abort_rdata", RDATA, 32'd0);
        chk_regs("abort_regs");
        @(posedge ACLK);
        #1;

        // Reset with AW latched and W pending: the half write is discarded.
        AWADDR = 5'h0C; AWVALID = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
        do_reset();
        WDATA = 32'hCAFECAFE; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK);
        #1;
        WVALID = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            chk("half_wr_bvalid", {31'b0, BVALID}, 32'd0);
            chk("half_wr_awready", {31'b0, AWREADY}, 32'd1);
            chk("half_wr_reg", reg_out[96 +: 32], 32'd0);
        end
        @(posedge ACLK);
        #1;
        do_reset();

        axi_write(5'h0C, 32'h600D600D, 4'hF, OK);
        axi_read(5'h0C, 32'h600D600D, OK);
        shadow[3] = 32'h600D600D;
        @(negedge ACLK);
        chk_regs("final_regs");

        repeat (2) @(posedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit read/write registers.
- It is the target end of the master-BFM write/read traffic. It sits behind the S00_AXI port of the kuzne4ik IP and holds the control/data words the core consumes.
- Single outstanding transaction per direction. The read and write channels operate independently.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI byte-address width; must satisfy 2^ADDR_WIDTH >= 4*NUM_REGS.
- NUM_REGS, 4, number of 32-bit registers, at byte offsets 0x0, 0x4, 0x8, 0xC, ...

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- AWADDR  in  ADDR_WIDTH  write address
- AWPROT  in  3  ignored
- AWVALID  in  1 / AWREADY  out  1
- WDATA  in  32 / WSTRB  in  4 / WVALID  in  1 / WREADY  out  1
- BRESP  out  2 / BVALID  out  1 / BREADY  in  1
- ARADDR  in  ADDR_WIDTH / ARPROT  in  3 (ignored) / ARVALID  in  1 / ARREADY  out  1
- RDATA  out  32 / RRESP  out  2 / RVALID  out  1 / RREADY  in  1
- reg_out  out  32*NUM_REGS  flattened register contents to the core; reg i occupies bits [32i+31:32i]

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (ARESET=1 at an edge) clears all registers to 0 and drops all in-flight state:
  - AWREADY=WREADY=ARREADY=1.
  - BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY=1 until an AW beat is latched; WREADY=1 until a W beat is latched. AW and W may arrive in either order or in the same cycle.
  - Each channel drops its READY the cycle after its handshake and stays low until the write completes.
  - When both AW and W are latched (including the same-cycle case), the register is updated at that edge and the FSM enters W_RESP. BVALID=1 from the next cycle.
  - Register update is byte-wise under WSTRB. WSTRB=0 leaves the register unchanged but still returns OKAY.
  - Word index = AWADDR[ADDR_WIDTH-1:2]. AWADDR[1:0] is ignored.
  - W_RESP: BVALID held with constant BRESP until BREADY. On the BVALID&BREADY edge: return to W_IDLE, BVALID=0, AWREADY=WREADY=1.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, RDATA and RRESP are captured at that edge, then RVALID=1 and ARREADY=0 (1-cycle latency).
  - R_DATA: RDATA/RRESP held stable until RREADY. The handshake edge returns to R_IDLE with RVALID=0.
- Address decode: index >= NUM_REGS gives SLVERR (2'b10).
  - Writes: no register changes.
  - Reads: RDATA=0.
  - In-range accesses give OKAY (2'b00). EXOKAY is never returned.
- Simultaneous read and write commit to the same register in one cycle: the read captures the pre-write value. The new value is visible to any AR handshake on a later edge.
- reg_out reflects a write in the cycle after the commit edge.
- VALID from the master without READY: no state change. Inputs are sampled only on handshake.
- Reset asserted mid-transaction aborts it. Any un-committed write is discarded, and no BVALID/RVALID is issued afterwards for it.

Decomposition:
- Package axil_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10.
  - Write-FSM and read-FSM state enums.
  - Helper function for byte-strobe merge.
- One natural sub-module, axil_reg_bank: the register array with strobe write port, async read mux and flattened reg_out.
- The top level contains both channel FSMs.

Test Plan:
- Reset then sequential write/read at 0x0, 0x4, 0x8, 0xC with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011, WSTRB=4'hF -> each BRESP=OKAY, each read returns the same word with RRESP=OKAY, reg_out matches.
- AW presented 3 cycles before W, then W before AW, then both in the same cycle -> exactly one register update each, BVALID one cycle after the later handshake.
- Write 0xFFFFFFFF to 0x4, then 0x12345678 with WSTRB=4'b0101 -> read 0x4 returns 0xFF34FF78.
- Hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID/RVALID and BRESP/RDATA stable, no new AW/AR accepted. With NUM_REGS=4 and ADDR_WIDTH=5, access 0x10 -> SLVERR, read data 0, no register changes.
- Write 0xA5A5A5A5 to 0x8 and AR to 0x8 committing on the same edge, with old value 0xdead0011 -> RDATA=0xdead0011; the following read returns 0xA5A5A5A5.
- Assert ARESET while BVALID=1 and with AW latched/W pending -> next cycle BVALID=0, RVALID=0, all READYs=1, all registers 0, no stray response.
